// File: rtl/pim_result_accumulator_pkg.sv
// Shared tile types and dimensions for the PIM partition, pim_unit and result accumulator.
package pim_result_accumulator_pkg;

  localparam int ELEM_WIDTH      = 32;
  localparam int PIM_MATRIX_SIZE = 8;

  typedef logic [ELEM_WIDTH-1:0] elem_t;
  typedef elem_t tile_t [PIM_MATRIX_SIZE][PIM_MATRIX_SIZE];

endpackage

// File: rtl/pim_tile_adder.sv
// Purely combinational element-wise modulo-2^ELEM_WIDTH adder of two tiles.
module pim_tile_adder
  import pim_result_accumulator_pkg::*;
(
  input  tile_t i_a,
  input  tile_t i_b,
  output tile_t o_sum
);

  // Element-wise sum; the carry out of each element is discarded.
  always_comb begin
    for (int r = 0; r < PIM_MATRIX_SIZE; r++) begin
      for (int c = 0; c < PIM_MATRIX_SIZE; c++) begin
        o_sum[r][c] = i_a[r][c] + i_b[r][c];
      end
    end
  end

endmodule

// File: rtl/pim_result_accumulator.sv
// Sums NUM_K_TILES consecutive partial tiles into one C tile and offers it
// downstream through a valid/ready handshake with a sticky overflow flag.
module pim_result_accumulator
  import pim_result_accumulator_pkg::*;
#(
  parameter  int NUM_K_TILES = 4,
  parameter  int IDX_WIDTH   = 16,
  localparam int KW          = $clog2(NUM_K_TILES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  tile_t                in_tile,
  output logic                 in_ready,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output tile_t                out_tile,
  output logic [IDX_WIDTH-1:0] out_tile_idx,
  output logic [KW-1:0]        k_count,
  output logic                 overflow
);

  localparam logic [KW-1:0]        LP_K_LAST  = KW'(NUM_K_TILES - 1);
  localparam logic [KW-1:0]        LP_K_ONE   = KW'(1);
  localparam logic [IDX_WIDTH-1:0] LP_IDX_ONE = IDX_WIDTH'(1);

  logic [KW-1:0]        r_k;
  logic                 r_out_valid;
  logic [IDX_WIDTH-1:0] r_idx;
  logic                 r_overflow;
  logic                 r_first;
  tile_t                r_acc;
  tile_t                r_out_tile;

  logic  w_last;
  logic  w_in_ready;
  logic  w_accept;
  logic  w_drop;
  tile_t w_op_a;
  tile_t w_sum;

  // The final partial stalls only while a finished tile is still pending;
  // deliberately independent of out_ready to avoid a combinational path.
  assign w_last     = (r_k == LP_K_LAST);
  assign w_in_ready = !(w_last && r_out_valid);
  assign w_accept   = in_valid && w_in_ready && !clear;
  assign w_drop     = in_valid && !w_in_ready && !clear;

  // First partial of a group overwrites: feed a zero tile into the adder.
  always_comb begin
    for (int r = 0; r < PIM_MATRIX_SIZE; r++) begin
      for (int c = 0; c < PIM_MATRIX_SIZE; c++) begin
        w_op_a[r][c] = (r_k == '0) ? '0 : r_acc[r][c];
      end
    end
  end

  pim_tile_adder u_adder (
    .i_a   (w_op_a),
    .i_b   (in_tile),
    .o_sum (w_sum)
  );

  // Control state: group position, output handshake, tile index, overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      r_first     <= 1'b1;
    end else if (clear) begin
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      r_first     <= 1'b1;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_k         <= '0;
          if (r_first) begin
            r_idx   <= '0;
            r_first <= 1'b0;
          end else begin
            r_idx <= r_idx + LP_IDX_ONE;
          end
        end else begin
          r_k <= r_k + LP_K_ONE;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Data path: running sum and finished tile; clear leaves both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < PIM_MATRIX_SIZE; r++) begin
        for (int c = 0; c < PIM_MATRIX_SIZE; c++) begin
          r_acc[r][c]      <= '0;
          r_out_tile[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      if (w_last) begin
        r_out_tile <= w_sum;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_tile     = r_out_tile;
  assign out_tile_idx = r_idx;
  assign k_count      = r_k;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_pim_result_accumulator.sv
// Directed bench: K=4 main instance, K=2 wrap instance, K=1 pass-through instance.
module tb_pim_result_accumulator;
  import pim_result_accumulator_pkg::*;

  logic clk;
  logic rst;

  logic        a_in_valid, a_clear, a_out_ready, a_out_valid, a_ovf, a_in_ready;
  tile_t       a_in_tile, a_out_tile;
  logic [15:0] a_idx;
  logic [2:0]  a_k;

  logic        b_in_valid, b_clear, b_out_ready, b_out_valid, b_ovf, b_in_ready;
  tile_t       b_in_tile, b_out_tile;
  logic [15:0] b_idx;
  logic [1:0]  b_k;

  logic        c_in_valid, c_clear, c_out_ready, c_out_valid, c_ovf, c_in_ready;
  tile_t       c_in_tile, c_out_tile;
  logic [15:0] c_idx;
  logic [0:0]  c_k;

  int total = 0;
  int bad   = 0;

  pim_result_accumulator #(.NUM_K_TILES(4), .IDX_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_tile(a_in_tile), .in_ready(a_in_ready),
    .clear(a_clear), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tile(a_out_tile),
    .out_tile_idx(a_idx), .k_count(a_k), .overflow(a_ovf));

  pim_result_accumulator #(.NUM_K_TILES(2), .IDX_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_tile(b_in_tile), .in_ready(b_in_ready),
    .clear(b_clear), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tile(b_out_tile),
    .out_tile_idx(b_idx), .k_count(b_k), .overflow(b_ovf));

  pim_result_accumulator #(.NUM_K_TILES(1), .IDX_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_tile(c_in_tile), .in_ready(c_in_ready),
    .clear(c_clear), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_tile(c_out_tile),
    .out_tile_idx(c_idx), .k_count(c_k), .overflow(c_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element [r][c] = base + step * (r*8 + c).
  function automatic tile_t pat(input logic [31:0] base, input logic [31:0] step);
    tile_t t;
    for (int r = 0; r < PIM_MATRIX_SIZE; r++)
      for (int c = 0; c < PIM_MATRIX_SIZE; c++)
        t[r][c] = base + step * 32'(r * PIM_MATRIX_SIZE + c);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input tile_t t, input logic [31:0] base,
                          input logic [31:0] step);
    tile_t x;
    logic [31:0] o, e;
    x = pat(base, step);
    o = t[0][0];
    e = x[0][0];
    for (int r = 0; r < PIM_MATRIX_SIZE; r++)
      for (int c = 0; c < PIM_MATRIX_SIZE; c++)
        if (t[r][c] !== x[r][c]) begin
          o = t[r][c];
          e = x[r][c];
        end
    chk(tag, {32'h0, o}, {32'h0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle presentation of a tile on instance 0 (K=4), 1 (K=2) or 2 (K=1).
  task automatic send(input int w, input tile_t t);
    case (w)
      0: begin a_in_valid = 1'b1; a_in_tile = t; end
      1: begin b_in_valid = 1'b1; b_in_tile = t; end
      default: begin c_in_valid = 1'b1; c_in_tile = t; end
    endcase
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_clear = 0; a_out_ready = 0; a_in_tile = pat(0, 0);
    b_in_valid = 0; b_clear = 0; b_out_ready = 0; b_in_tile = pat(0, 0);
    c_in_valid = 0; c_clear = 0; c_out_ready = 0; c_in_tile = pat(0, 0);
    repeat (2) tick();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_k", a_k, 3'd0);
    chk("rst_idx", a_idx, 16'd0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk_tile("rst_tile", a_out_tile, 0, 0);
    rst = 1'b0;
    tick();

    // K=2 modulo wrap
    send(1, pat(32'hFFFF_FFFF, 0));
    chk("b_k1", b_k, 2'd1);
    send(1, pat(32'h0000_0002, 0));
    chk("b_wrap_valid", b_out_valid, 1'b1);
    chk_tile("b_wrap_tile", b_out_tile, 32'h1, 0);
    chk("b_wrap_ovf", b_ovf, 1'b0);

    // K=1 pass-through with stall while pending
    send(2, pat(7, 3));
    chk("c_valid0", c_out_valid, 1'b1);
    chk_tile("c_tile0", c_out_tile, 7, 3);
    chk("c_idx0", c_idx, 16'd0);
    chk("c_ready_low", c_in_ready, 1'b0);
    send(2, pat(9, 1));
    chk("c_ovf", c_ovf, 1'b1);
    chk_tile("c_tile_held", c_out_tile, 7, 3);
    c_out_ready = 1'b1;
    tick();
    chk("c_drained", c_out_valid, 1'b0);
    chk("c_ready_back", c_in_ready, 1'b1);
    send(2, pat(9, 1));
    chk_tile("c_tile1", c_out_tile, 9, 1);
    chk("c_idx1", c_idx, 16'd1);

    // K=4 basic: partials p=1..4, each base p step p -> base 10 step 10
    a_out_ready = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      chk("a_out_valid_pre", a_out_valid, 1'b0);
      send(0, pat(p, p));
    end
    chk("a_g1_valid", a_out_valid, 1'b1);
    chk_tile("a_g1_tile", a_out_tile, 10, 10);
    chk("a_g1_idx", a_idx, 16'd0);
    chk("a_g1_k", a_k, 3'd0);
    send(0, pat(1, 0));
    chk("a_g1_drained", a_out_valid, 1'b0);
    chk("a_g2_k1", a_k, 3'd1);
    for (int p = 0; p < 3; p++) send(0, pat(1, 0));
    chk("a_g2_valid", a_out_valid, 1'b1);
    chk_tile("a_g2_tile", a_out_tile, 4, 0);
    chk("a_g2_idx", a_idx, 16'd1);
    tick();
    chk("a_g2_drained", a_out_valid, 1'b0);

    // Backpressure: group A sums to 5, group B stalls on its final partial
    a_out_ready = 1'b0;
    send(0, pat(1, 0)); send(0, pat(1, 0)); send(0, pat(1, 0)); send(0, pat(2, 0));
    chk_tile("a_A_tile", a_out_tile, 5, 0);
    chk("a_A_idx", a_idx, 16'd2);
    for (int p = 0; p < 3; p++) send(0, pat(1, 1));
    chk("a_B_k3", a_k, 3'd3);
    chk("a_B_ready_low", a_in_ready, 1'b0);
    send(0, pat(1, 1));
    chk("a_B_drop_ovf", a_ovf, 1'b1);
    chk("a_B_drop_k", a_k, 3'd3);
    chk_tile("a_B_drop_tile", a_out_tile, 5, 0);
    chk("a_B_drop_idx", a_idx, 16'd2);
    a_out_ready = 1'b1;
    tick();
    chk("a_A_drained", a_out_valid, 1'b0);
    chk("a_B_ready_back", a_in_ready, 1'b1);
    a_out_ready = 1'b0;
    send(0, pat(1, 1));
    chk("a_B_valid", a_out_valid, 1'b1);
    chk_tile("a_B_tile", a_out_tile, 4, 4);
    chk("a_B_idx", a_idx, 16'd3);
    chk("a_ovf_sticky", a_ovf, 1'b1);

    // Non-final partials accumulate while B is pending, then clear
    send(0, pat(50, 0)); send(0, pat(50, 0));
    chk("a_pre_clear_k", a_k, 3'd2);
    chk("a_pre_clear_valid", a_out_valid, 1'b1);
    a_clear = 1'b1; a_out_ready = 1'b1;
    send(0, pat(50, 0));
    a_clear = 1'b0; a_out_ready = 1'b0;
    chk("a_clr_k", a_k, 3'd0);
    chk("a_clr_valid", a_out_valid, 1'b0);
    chk("a_clr_idx", a_idx, 16'd0);
    chk("a_clr_ovf", a_ovf, 1'b0);
    chk_tile("a_clr_tile_kept", a_out_tile, 4, 4);
    for (int p = 0; p < 4; p++) send(0, pat(2, 0));
    chk_tile("a_postclr_tile", a_out_tile, 8, 0);
    chk("a_postclr_idx", a_idx, 16'd0);
    a_out_ready = 1'b1;
    for (int p = 0; p < 4; p++) send(0, pat(1, 0));
    chk("a_postclr2_idx", a_idx, 16'd1);
    a_out_ready = 1'b0;
    send(0, pat(1, 0)); send(0, pat(1, 0));
    chk("a_prerst_k", a_k, 3'd2);
    chk("a_prerst_valid", a_out_valid, 1'b1);

    // Async reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_k", a_k, 3'd0);
    chk("arst_idx", a_idx, 16'd0);
    chk_tile("arst_tile", a_out_tile, 0, 0);
    chk("arst_b_valid", b_out_valid, 1'b0);
    #1 rst = 1'b0;
    a_out_ready = 1'b1;
    for (int p = 0; p < 4; p++) send(0, pat(3, 1));
    chk("a_postrst_valid", a_out_valid, 1'b1);
    chk_tile("a_postrst_tile", a_out_tile, 12, 4);
    chk("a_postrst_idx", a_idx, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
